// File: rtl/can_fd_crc_field_rx_if.sv
// -----------------------------------------------------------------------------
// can_fd_crc_field_rx_if
// Bundles the signals between the bit sampler / frame state machine and the
// CAN FD CRC-field receiver. Names are from the receiver's point of view.
//   i_start          pulse on the cycle before the first CRC-field bit
//   i_abort          error/overload frame, drop back to idle
//   i_sample_valid   i_data holds a new sampled bit
//   i_data           sampled bus bit
//   i_data_prev      previously sampled bus bit
//   i_crc_b_sel      1 = long CRC mode (latched at start)
//   i_stuff_cnt_exp  dynamic stuff count mod 8 (latched at start)
//   i_crc_calc_a/b   receiver-computed CRCs, valid at done
//   o_busy, o_done, o_pos, o_crc, o_stuff_cnt   status / captured values
//   o_fixed_stuff_bit_error, o_sbc_parity_error, o_sbc_value_error,
//   o_crc_error      error flags
// Modports: master = sampler/frame side, slave = receiver.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface can_fd_crc_field_rx_if #(
    parameter int CRC_A_W = 17,
    parameter int CRC_B_W = 21,
    parameter int POS_W   = 6
);
    logic               i_start;
    logic               i_abort;
    logic               i_sample_valid;
    logic               i_data;
    logic               i_data_prev;
    logic               i_crc_b_sel;
    logic [2:0]         i_stuff_cnt_exp;
    logic [CRC_A_W-1:0] i_crc_calc_a;
    logic [CRC_B_W-1:0] i_crc_calc_b;
    logic               o_busy;
    logic               o_done;
    logic [POS_W-1:0]   o_pos;
    logic [CRC_B_W-1:0] o_crc;
    logic [2:0]         o_stuff_cnt;
    logic               o_fixed_stuff_bit_error;
    logic               o_sbc_parity_error;
    logic               o_sbc_value_error;
    logic               o_crc_error;

    modport master (
        output i_start, i_abort, i_sample_valid, i_data, i_data_prev,
               i_crc_b_sel, i_stuff_cnt_exp, i_crc_calc_a, i_crc_calc_b,
        input  o_busy, o_done, o_pos, o_crc, o_stuff_cnt,
               o_fixed_stuff_bit_error, o_sbc_parity_error,
               o_sbc_value_error, o_crc_error
    );

    modport slave (
        input  i_start, i_abort, i_sample_valid, i_data, i_data_prev,
               i_crc_b_sel, i_stuff_cnt_exp, i_crc_calc_a, i_crc_calc_b,
        output o_busy, o_done, o_pos, o_crc, o_stuff_cnt,
               o_fixed_stuff_bit_error, o_sbc_parity_error,
               o_sbc_value_error, o_crc_error
    );
endinterface

// File: rtl/can_fd_crc_field_rx.sv
// -----------------------------------------------------------------------------
// can_fd_crc_field_rx
// Receives the CAN FD CRC field (stuff-count sub-field + CRC sequence), strips
// and checks the fixed stuff bits, decodes the Gray-coded stuff count and
// compares the received CRC with the receiver-computed one.
// Ports:
//   i_clk  clock
//   i_rst  asynchronous active-high reset
//   bus    can_fd_crc_field_rx_if.slave (handshake, data and status)
//
// state  | meaning
// -------+---------------------------------------------------
// S_IDLE | waiting for start, captured values held
// S_SBC  | receiving stuff-count sub-field (Gray + parity)
// S_CRC  | receiving CRC sequence
// S_DONE | one-cycle done pulse, crc_error valid
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module can_fd_crc_field_rx #(
    parameter int STUFF_PERIOD = 5,
    parameter int SBC_W        = 4,
    parameter int CRC_A_W      = 17,
    parameter int CRC_B_W      = 21,
    parameter int POS_W        = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    can_fd_crc_field_rx_if.slave bus
);
    localparam int PH_W = $clog2(STUFF_PERIOD);
    localparam int SC_W = $clog2(SBC_W);

    // Position of the last data bit: data bits fill STUFF_PERIOD-1 slots per
    // group, each group led by one fixed stuff bit.
    localparam int D_A = SBC_W + CRC_A_W;
    localparam int D_B = SBC_W + CRC_B_W;
    localparam int LAST_A_I = ((D_A-1)/(STUFF_PERIOD-1))*STUFF_PERIOD + (D_A-1)%(STUFF_PERIOD-1) + 1;
    localparam int LAST_B_I = ((D_B-1)/(STUFF_PERIOD-1))*STUFF_PERIOD + (D_B-1)%(STUFF_PERIOD-1) + 1;
    localparam logic [POS_W-1:0] LAST_A = POS_W'(LAST_A_I);
    localparam logic [POS_W-1:0] LAST_B = POS_W'(LAST_B_I);

    typedef enum logic [1:0] {S_IDLE, S_SBC, S_CRC, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [POS_W-1:0]   r_pos;
    logic [PH_W-1:0]    r_phase;
    logic [SC_W-1:0]    r_sbc_cnt;
    logic [SBC_W-2:0]   r_sbc;
    logic [CRC_B_W-1:0] r_crc;
    logic               r_crc_b;
    logic [2:0]         r_cnt_exp;
    logic [2:0]         r_stuff_cnt;
    logic               r_fix_err;
    logic               r_par_err;
    logic               r_val_err;

    logic               w_accept;
    logic               w_stuff;
    logic               w_sbc_last;
    logic [POS_W-1:0]   w_last_pos;
    logic [SBC_W-1:0]   w_sbc_word;
    logic [2:0]         w_gray;
    logic [2:0]         w_bin;

    // start and abort both discard a bit sampled in the same cycle
    assign w_accept   = bus.i_sample_valid && !bus.i_start && !bus.i_abort &&
                        (r_state == S_SBC || r_state == S_CRC);
    assign w_stuff    = (r_phase == '0);
    assign w_sbc_last = (r_sbc_cnt == SC_W'(SBC_W-1));
    assign w_last_pos = r_crc_b ? LAST_B : LAST_A;
    assign w_sbc_word = {r_sbc, bus.i_data};
    assign w_gray     = w_sbc_word[SBC_W-1 -: 3];
    assign w_bin      = {w_gray[2], w_gray[2]^w_gray[1], w_gray[2]^w_gray[1]^w_gray[0]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = S_IDLE;
            S_SBC:  if (w_accept && !w_stuff && w_sbc_last) w_next = S_CRC;
            S_CRC:  if (w_accept && (r_pos == w_last_pos))  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.i_abort) w_next = S_IDLE;
        if (bus.i_start) w_next = S_SBC;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pos       <= '0;
            r_phase     <= '0;
            r_sbc_cnt   <= '0;
            r_sbc       <= '0;
            r_crc       <= '0;
            r_crc_b     <= 1'b0;
            r_cnt_exp   <= '0;
            r_stuff_cnt <= '0;
            r_fix_err   <= 1'b0;
            r_par_err   <= 1'b0;
            r_val_err   <= 1'b0;
        end else if (bus.i_start) begin
            r_pos       <= '0;
            r_phase     <= '0;
            r_sbc_cnt   <= '0;
            r_sbc       <= '0;
            r_crc       <= '0;
            r_crc_b     <= bus.i_crc_b_sel;
            r_cnt_exp   <= bus.i_stuff_cnt_exp;
            r_stuff_cnt <= '0;
            r_fix_err   <= 1'b0;
            r_par_err   <= 1'b0;
            r_val_err   <= 1'b0;
        end else if (w_accept) begin
            r_pos   <= r_pos + 1'b1;
            r_phase <= (r_phase == PH_W'(STUFF_PERIOD-1)) ? '0 : r_phase + 1'b1;
            if (w_stuff) begin
                if (bus.i_data == bus.i_data_prev) r_fix_err <= 1'b1;
            end else if (r_state == S_SBC) begin
                r_sbc     <= w_sbc_word[SBC_W-2:0];
                r_sbc_cnt <= r_sbc_cnt + 1'b1;
                if (w_sbc_last) begin
                    r_stuff_cnt <= w_bin;
                    r_par_err   <= (^w_gray) != w_sbc_word[0];
                    r_val_err   <= (w_bin != r_cnt_exp);
                end
            end else begin
                // zero-cleared at start, so A mode ends up right-aligned
                r_crc <= {r_crc[CRC_B_W-2:0], bus.i_data};
            end
        end
    end

    assign bus.o_busy                  = (r_state == S_SBC) || (r_state == S_CRC);
    assign bus.o_done                  = (r_state == S_DONE);
    assign bus.o_pos                   = r_pos;
    assign bus.o_crc                   = r_crc;
    assign bus.o_stuff_cnt             = r_stuff_cnt;
    assign bus.o_fixed_stuff_bit_error = r_fix_err;
    assign bus.o_sbc_parity_error      = r_par_err;
    assign bus.o_sbc_value_error       = r_val_err;
    assign bus.o_crc_error             = (r_state == S_DONE) &&
        (r_crc_b ? (r_crc != bus.i_crc_calc_b)
                 : (r_crc != {{(CRC_B_W-CRC_A_W){1'b0}}, bus.i_crc_calc_a}));
endmodule

// File: tb/tb_can_fd_crc_field_rx.sv
`timescale 1ns/1ps
module tb_can_fd_crc_field_rx;
    localparam int CRC_A_W = 17;
    localparam int CRC_B_W = 21;
    localparam int POS_W   = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    can_fd_crc_field_rx_if #(.CRC_A_W(CRC_A_W), .CRC_B_W(CRC_B_W), .POS_W(POS_W)) bus();

    can_fd_crc_field_rx #(
        .STUFF_PERIOD(5), .SBC_W(4), .CRC_A_W(CRC_A_W), .CRC_B_W(CRC_B_W), .POS_W(POS_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct {
        logic        crc_b;
        logic [2:0]  gray;
        logic        par;
        logic [20:0] crc;
        logic [20:0] calc;
        logic [2:0]  exp_in;
        int          err_pos;
        logic        e_crcerr;
        logic        e_fix;
        logic        e_par;
        logic        e_val;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_err    = 0;

    // field bit stream and reference results
    logic        bits[32];
    logic        exp_fix[32];
    int          nbits;
    logic        prev0;
    logic [20:0] m_crc;
    logic [2:0]  m_cnt;
    logic        m_fix, m_par, m_val, m_crcerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serialise one field: fixed stuff bit every 5th position (inverse of the
    // previous bus bit unless err_pos selects a bad one), payload MSB first.
    task automatic build_field(input logic b, input logic [2:0] g, input logic p,
                               input logic [20:0] c, input int err_pos);
        logic pay[$];
        logic pv;
        int   w;
        pv    = prev0;
        nbits = b ? 32 : 27;
        w     = b ? 21 : 17;
        pay.delete();
        pay.push_back(g[2]); pay.push_back(g[1]); pay.push_back(g[0]); pay.push_back(p);
        for (int i = w-1; i >= 0; i--) pay.push_back(c[i]);
        for (int pp = 0; pp < nbits; pp++) begin
            if (pp % 5 == 0) bits[pp] = (pp == err_pos) ? pv : ~pv;
            else             bits[pp] = pay.pop_front();
            pv = bits[pp];
        end
    endtask

    // Reference: parse the serial stream back into sub-fields with plain arithmetic.
    task automatic model(input logic [2:0] exp_cnt, input logic [20:0] calc);
        logic        pv;
        int          d;
        logic [3:0]  sbc;
        logic [20:0] c;
        logic        f;
        int          gr, bn;
        pv = prev0; d = 0; sbc = '0; c = '0; f = 1'b0;
        for (int p = 0; p < nbits; p++) begin
            if (p % 5 == 0) begin
                if (bits[p] == pv) f = 1'b1;
            end else begin
                if (d < 4) sbc = {sbc[2:0], bits[p]};
                else       c   = {c[19:0], bits[p]};
                d++;
            end
            pv = bits[p];
            exp_fix[p] = f;
        end
        gr = int'(sbc[3:1]);
        bn = gr ^ (gr >> 1) ^ (gr >> 2);
        m_cnt    = bn[2:0];
        m_par    = (sbc[0] != (($countones(sbc[3:1]) % 2) == 1));
        m_val    = (bn[2:0] != exp_cnt);
        m_crc    = c;
        m_fix    = f;
        m_crcerr = (c != calc);
    endtask

    task automatic drive_bit(input int p);
        bus.i_sample_valid = 1'b1;
        bus.i_data         = bits[p];
        bus.i_data_prev    = (p == 0) ? prev0 : bits[p-1];
        step();
        bus.i_sample_valid = 1'b0;
    endtask

    task automatic do_start(input logic b, input logic [2:0] exp_cnt, input logic [20:0] calc);
        bus.i_start         = 1'b1;
        bus.i_crc_b_sel     = b;
        bus.i_stuff_cnt_exp = exp_cnt;
        bus.i_crc_calc_a    = calc[16:0];
        bus.i_crc_calc_b    = calc;
        step();
        bus.i_start         = 1'b0;
        // must have been latched; scramble to prove it
        bus.i_crc_b_sel     = 1'($urandom);
        bus.i_stuff_cnt_exp = 3'($urandom);
    endtask

    task automatic run_field(input logic b, input logic [2:0] exp_cnt, input logic [20:0] calc,
                             input logic [20:0] e_crc, input logic [2:0] e_cnt, input logic e_fix,
                             input logic e_par, input logic e_val, input logic e_crcerr, input string tag);
        do_start(b, exp_cnt, calc);
        chk({tag, " busy_at_start"}, 32'(bus.o_busy), 1);
        chk({tag, " fix_clear_at_start"}, 32'(bus.o_fixed_stuff_bit_error), 0);
        for (int p = 0; p < nbits; p++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.i_data      = 1'($urandom);
                bus.i_data_prev = 1'($urandom);
                step();
            end
            drive_bit(p);
            chk({tag, " pos"}, 32'(bus.o_pos), p + 1);
            chk({tag, " fix_running"}, 32'(bus.o_fixed_stuff_bit_error), 32'(exp_fix[p]));
            if (p < nbits - 1) chk({tag, " done_early"}, 32'(bus.o_done), 0);
        end
        chk({tag, " done"}, 32'(bus.o_done), 1);
        chk({tag, " busy_in_done"}, 32'(bus.o_busy), 0);
        chk({tag, " crc_o"}, 32'(bus.o_crc), 32'(e_crc));
        chk({tag, " stuff_cnt"}, 32'(bus.o_stuff_cnt), 32'(e_cnt));
        chk({tag, " fixed_err"}, 32'(bus.o_fixed_stuff_bit_error), 32'(e_fix));
        chk({tag, " par_err"}, 32'(bus.o_sbc_parity_error), 32'(e_par));
        chk({tag, " val_err"}, 32'(bus.o_sbc_value_error), 32'(e_val));
        chk({tag, " crc_err"}, 32'(bus.o_crc_error), 32'(e_crcerr));
        step();
        chk({tag, " done_single"}, 32'(bus.o_done), 0);
        chk({tag, " crc_err_after"}, 32'(bus.o_crc_error), 0);
        chk({tag, " crc_hold"}, 32'(bus.o_crc), 32'(e_crc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        b, par;
        logic [2:0]  g, ex;
        logic [20:0] c, calc;
        int          ep;

        vecs[0] = '{1'b0, 3'b111, 1'b1, 21'h1A5C3,  21'h1A5C3,  3'd5, -1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5};
        vecs[1] = '{1'b1, 3'b010, 1'b1, 21'h0F00F,  21'h0F00E,  3'd3, -1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
        vecs[2] = '{1'b0, 3'b111, 1'b1, 21'h0B3A1,  21'h0B3A1,  3'd5, 15, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5};
        vecs[3] = '{1'b0, 3'b011, 1'b1, 21'h00055,  21'h00055,  3'd1, -1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2};
        vecs[4] = '{1'b1, 3'b100, 1'b1, 21'h1FFFFF, 21'h1FFFFF, 3'd7, -1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7};
        vecs[5] = '{1'b0, 3'b000, 1'b0, 21'h00000,  21'h00001,  3'd0,  0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[6] = '{1'b1, 3'b110, 1'b0, 21'h12345,  21'h12345,  3'd4, 30, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4};
        vecs[7] = '{1'b0, 3'b001, 1'b1, 21'h10000,  21'h00000,  3'd1, -1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1};

        rst = 1'b1;
        bus.i_start = 0; bus.i_abort = 0; bus.i_sample_valid = 0; bus.i_data = 0;
        bus.i_data_prev = 0; bus.i_crc_b_sel = 0; bus.i_stuff_cnt_exp = 0;
        bus.i_crc_calc_a = 0; bus.i_crc_calc_b = 0;
        step(); step();
        chk("reset busy", 32'(bus.o_busy), 0);
        chk("reset done", 32'(bus.o_done), 0);
        chk("reset pos", 32'(bus.o_pos), 0);
        chk("reset crc", 32'(bus.o_crc), 0);
        chk("reset errs", 32'({bus.o_fixed_stuff_bit_error, bus.o_sbc_parity_error,
                               bus.o_sbc_value_error, bus.o_crc_error, bus.o_stuff_cnt}), 0);
        rst = 1'b0;
        step();

        // directed table
        for (int i = 0; i < 8; i++) begin
            prev0 = 1'(i);
            build_field(vecs[i].crc_b, vecs[i].gray, vecs[i].par, vecs[i].crc, vecs[i].err_pos);
            model(vecs[i].exp_in, vecs[i].calc);
            run_field(vecs[i].crc_b, vecs[i].exp_in, vecs[i].calc, vecs[i].crc, vecs[i].e_cnt,
                      vecs[i].e_fix, vecs[i].e_par, vecs[i].e_val, vecs[i].e_crcerr,
                      $sformatf("vec%0d", i));
        end

        // abort at pos 12, then a clean field
        prev0 = 1'b0;
        build_field(1'b0, 3'b111, 1'b1, 21'h1A5C3, 5);
        do_start(1'b0, 3'd5, 21'h1A5C3);
        for (int p = 0; p < 12; p++) drive_bit(p);
        bus.i_abort = 1'b1;
        step();
        bus.i_abort = 1'b0;
        chk("abort busy", 32'(bus.o_busy), 0);
        chk("abort done", 32'(bus.o_done), 0);
        chk("abort pos_kept", 32'(bus.o_pos), 12);
        chk("abort fix_kept", 32'(bus.o_fixed_stuff_bit_error), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort no_done", 32'(bus.o_done), 0);
        end
        build_field(1'b0, 3'b111, 1'b1, 21'h1A5C3, -1);
        model(3'd5, 21'h1A5C3);
        run_field(1'b0, 3'd5, 21'h1A5C3, 21'h1A5C3, 3'd5, 0, 0, 0, 0, "after_abort");

        // start + sample_valid same cycle, then async reset at pos 8
        prev0 = 1'b1;
        build_field(1'b0, 3'b111, 1'b1, 21'h1A5C3, -1);
        bus.i_sample_valid = 1'b1;
        bus.i_data         = 1'b1;
        bus.i_data_prev    = 1'b1;
        do_start(1'b0, 3'd5, 21'h1A5C3);
        bus.i_sample_valid = 1'b0;
        chk("start_sv pos", 32'(bus.o_pos), 0);
        chk("start_sv busy", 32'(bus.o_busy), 1);
        for (int p = 0; p < 8; p++) drive_bit(p);
        chk("pre_rst pos", 32'(bus.o_pos), 8);
        chk("pre_rst cnt", 32'(bus.o_stuff_cnt), 5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst busy", 32'(bus.o_busy), 0);
        chk("async_rst pos", 32'(bus.o_pos), 0);
        chk("async_rst crc", 32'(bus.o_crc), 0);
        chk("async_rst cnt", 32'(bus.o_stuff_cnt), 0);
        step();
        rst = 1'b0;
        bus.i_sample_valid = 1'b1;
        step();
        bus.i_sample_valid = 1'b0;
        chk("idle ignores_sv", 32'(bus.o_pos), 0);

        // restart mid-field with abort in the same cycle: start wins
        prev0 = 1'b0;
        build_field(1'b1, 3'b010, 1'b1, 21'h0F00F, 5);
        do_start(1'b1, 3'd3, 21'h0F00F);
        for (int p = 0; p < 10; p++) drive_bit(p);
        chk("restart fix_before", 32'(bus.o_fixed_stuff_bit_error), 1);
        bus.i_abort = 1'b1;
        do_start(1'b1, 3'd3, 21'h0F00F);
        bus.i_abort = 1'b0;
        chk("restart busy", 32'(bus.o_busy), 1);
        chk("restart pos", 32'(bus.o_pos), 0);
        chk("restart fix_clear", 32'(bus.o_fixed_stuff_bit_error), 0);
        chk("restart cnt_clear", 32'(bus.o_stuff_cnt), 0);
        bus.i_abort = 1'b1;
        step();
        bus.i_abort = 1'b0;
        chk("restart abort_idle", 32'(bus.o_busy), 0);

        // randomized fields against the reference model
        for (int it = 0; it < 24; it++) begin
            b     = 1'($urandom_range(0, 1));
            g     = 3'($urandom);
            par   = (^g) ^ ($urandom_range(0, 4) == 0);
            c     = 21'($urandom);
            if (!b) c[20:17] = 4'd0;
            calc  = c;
            if ($urandom_range(0, 2) == 0) calc = calc ^ (21'd1 << $urandom_range(0, b ? 20 : 16));
            ex    = ($urandom_range(0, 1) == 0) ? (g ^ (g >> 1) ^ (g >> 2)) : 3'($urandom);
            ep    = ($urandom_range(0, 2) == 0) ? 5 * $urandom_range(0, b ? 6 : 5) : -1;
            prev0 = 1'($urandom);
            build_field(b, g, par, c, ep);
            model(ex, calc);
            run_field(b, ex, calc, m_crc, m_cnt, m_fix, m_par, m_val, m_crcerr,
                      $sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
